// File: rtl/mac_inverse_div.sv
// Sequential inverse of the dadda MAC: recovers a = ({cout,mult_out} - x) / b
// by restoring division, with remainder and error flags, valid/ready on both sides.
module mac_inverse_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] mult_out,
    input  logic        cout,
    input  logic [15:0] x,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] a_q,
    output logic [7:0]  rem,
    output logic        div_zero,
    output logic        neg,
    output logic        ovf
);

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; the source holds its data and valid stable until that edge.

    typedef enum logic [1:0] {IDLE, SUB, DIV, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic [16:0] res_r;
    logic [15:0] x_r;
    logic [7:0]  b_r;
    logic [16:0] dvd;
    logic [16:0] quo;
    logic [7:0]  prem;
    logic [4:0]  cnt;

    logic        accept;
    logic [17:0] diff;
    logic        sub_neg;
    logic        sub_dz;
    logic [8:0]  rem_t;
    logic [8:0]  rem_sub;
    logic        take;
    logic [7:0]  rem_nxt;
    logic [16:0] quo_nxt;

    assign accept  = in_valid && in_ready;

    // 18-bit subtraction so the top bit is the borrow
    assign diff    = {1'b0, res_r} - {2'b00, x_r};
    assign sub_neg = diff[17];
    assign sub_dz  = (b_r == 8'd0);

    assign rem_t   = {prem, dvd[16]};
    assign rem_sub = rem_t - {1'b0, b_r};
    assign take    = (rem_t >= {1'b0, b_r});
    assign rem_nxt = take ? rem_sub[7:0] : rem_t[7:0];
    assign quo_nxt = {quo[15:0], take};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SUB;
            SUB:  state_nxt = (sub_neg || sub_dz) ? DONE : DIV;
            DIV:  if (cnt == 5'd0) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_r    <= '0;
            x_r      <= '0;
            b_r      <= '0;
            dvd      <= '0;
            quo      <= '0;
            prem     <= '0;
            cnt      <= '0;
            a_q      <= '0;
            rem      <= '0;
            div_zero <= 1'b0;
            neg      <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        res_r <= {cout, mult_out};
                        x_r   <= x;
                        b_r   <= b;
                    end
                end
                SUB: begin
                    if (sub_neg || sub_dz) begin
                        a_q      <= '0;
                        rem      <= '0;
                        div_zero <= sub_dz;
                        neg      <= sub_neg;
                        ovf      <= 1'b0;
                    end else begin
                        dvd  <= diff[16:0];
                        prem <= '0;
                        quo  <= '0;
                        cnt  <= 5'd16;
                    end
                end
                DIV: begin
                    dvd  <= {dvd[15:0], 1'b0};
                    prem <= rem_nxt;
                    quo  <= quo_nxt;
                    if (cnt == 5'd0) begin
                        // last quotient bit: publish the result registers
                        a_q      <= quo_nxt;
                        rem      <= rem_nxt;
                        ovf      <= |quo_nxt[16:8];
                        div_zero <= 1'b0;
                        neg      <= 1'b0;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_inverse_div.sv
// Directed and randomized round-trip bench for mac_inverse_div with an
// expected-result queue filled at accept time and drained at output time.
module tb_mac_inverse_div;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] mult_out;
    logic        cout;
    logic [15:0] x;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] a_q;
    logic [7:0]  rem;
    logic        div_zero;
    logic        neg;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    // {a_q, rem, div_zero, neg, ovf}
    logic [27:0] exp_q[$];

    mac_inverse_div dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mult_out (mult_out),
        .cout     (cout),
        .x        (x),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_q      (a_q),
        .rem      (rem),
        .div_zero (div_zero),
        .neg      (neg),
        .ovf      (ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [27:0] model(input logic [15:0] m, input logic c,
                                          input logic [15:0] xv, input logic [7:0] bv);
        int unsigned r;
        int unsigned q;
        int unsigned rm;
        logic        dz;
        logic        ng;
        r  = {15'd0, c, m};
        dz = (bv == 8'd0);
        ng = (r < {16'd0, xv});
        if (dz || ng) return {17'd0, 8'd0, dz, ng, 1'b0};
        q  = (r - xv) / bv;
        rm = (r - xv) % bv;
        return {q[16:0], rm[7:0], 1'b0, 1'b0, (q > 255)};
    endfunction

    function automatic logic [27:0] observed();
        return {a_q, rem, div_zero, neg, ovf};
    endfunction

    // driver: present operands, wait for in_ready, push expectation on accept
    task automatic send(input logic [15:0] m, input logic c, input logic [15:0] xv, input logic [7:0] bv);
        int n = 0;
        in_valid = 1'b1;
        mult_out = m;
        cout     = c;
        x        = xv;
        b        = bv;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(model(m, c, xv, bv));
        #1;
        in_valid = 1'b0;
    endtask

    // monitor: wait for out_valid, check latency and result, hold, then release
    task automatic receive(input int hold);
        int          lat = 0;
        logic [27:0] e;
        logic        busy_ok = 1'b1;
        out_ready = 1'b0;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
            if (in_ready !== 1'b0) busy_ok = 1'b0;
        end
        chk("busy_in_ready_low", {31'd0, busy_ok}, 32'd1);
        if (exp_q.size() == 0) begin
            chk("queue_underflow", 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        if (!out_valid) begin
            chk("result_timeout", 32'd0, 32'd1);
            return;
        end
        chk("latency", lat, (e[2] || e[1]) ? 32'd1 : 32'd18);
        chk("result", {4'd0, observed()}, {4'd0, e});
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            chk("hold_stable", {2'd0, out_valid, in_ready, observed()}, {2'd0, 1'b1, 1'b0, e});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("after_transfer", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
        chk("held_in_idle", {4'd0, observed()}, {4'd0, e});
    endtask

    initial begin
        logic [16:0] res;
        int unsigned av;
        int unsigned bv;
        int unsigned xv;
        int unsigned rv;
        int          seen;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mult_out  = '0;
        cout      = 1'b0;
        x         = '0;
        b         = '0;
        #1;
        chk("reset_state", {2'd0, in_ready, out_valid, observed()}, {2'd0, 1'b1, 1'b0, 28'd0});
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // round trip and boundaries
        send(16'h1689, 1'b0, 16'h1111, 8'd20);  receive(0);
        send(16'hA6F8, 1'b1, 16'hFF00, 8'd200); receive(0);
        send(16'hFE00, 1'b1, 16'hFFFF, 8'd255); receive(0);
        send(16'h168F, 1'b0, 16'h1111, 8'd20);  receive(0);
        send(16'h1000, 1'b0, 16'h0000, 8'd1);   receive(0);
        // error paths
        send(16'h1234, 1'b0, 16'h0000, 8'd0);   receive(0);
        send(16'h0010, 1'b0, 16'h0020, 8'd5);   receive(0);
        send(16'h0010, 1'b0, 16'h0020, 8'd0);   receive(0);
        // long hold with out_ready low
        send(16'h168F, 1'b0, 16'h1111, 8'd20);  receive(10);

        // back-to-back: second operand set waits for in_ready
        send(16'hA6F8, 1'b1, 16'hFF00, 8'd200);
        fork
            receive(2);
            send(16'h1689, 1'b0, 16'h1111, 8'd20);
        join
        receive(0);

        // randomized round trips
        for (int i = 0; i < 6; i++) begin
            av  = $urandom_range(0, 255);
            bv  = $urandom_range(1, 255);
            xv  = $urandom_range(0, 65535);
            rv  = $urandom_range(0, bv - 1);
            res = 17'(av * bv + xv + rv);
            send(res[15:0], res[16], xv[15:0], bv[7:0]);
            receive($urandom_range(0, 3));
        end

        // async reset in the middle of the division
        send(16'h0FFF, 1'b0, 16'h0000, 8'd7);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("mid_div_reset_clear", {2'd0, in_ready, out_valid, observed()}, {2'd0, 1'b1, 1'b0, 28'd0});
        void'(exp_q.pop_back());
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("no_result_after_reset", seen, 32'd0);
        send(16'h1689, 1'b0, 16'h1111, 8'd20);  receive(0);

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
